muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide unit for a MIPS-style pipeline: multi-cycle multiply,
// 32-iteration restoring divide, mthi/mtlo writes, flush and stall handling.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? -x : x;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x,
                                                 input logic neg);
    return neg ? -x : x;
  endfunction

  state_t              state;
  logic [5:0]          cnt;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo;
  logic                neg_q;
  logic                neg_r;
  logic                div0;

  logic                op_valid;
  logic                accept;
  logic                accept_long;
  logic                mul_sgn;
  logic signed [63:0]  mul_a;
  logic signed [63:0]  mul_b;
  logic signed [63:0]  product;
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;
  logic                fit;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;

  // Reset also masks the request path so stall_req is 0 while rst is held.
  assign op_valid    = ~(op[2] & op[1]);
  assign accept      = (state == IDLE) & start & ~flush & op_valid & ~rst;
  assign accept_long = accept & ~op[2];

  assign stall_req = (((state == MUL) | (state == DIV)) & ~flush) | accept_long;
  assign done      = (state == FIN) & ~flush;

  assign mul_sgn = ~op_q[0];
  assign mul_a   = {{DATA_W{mul_sgn & opa[DATA_W-1]}}, opa};
  assign mul_b   = {{DATA_W{mul_sgn & opb[DATA_W-1]}}, opb};
  assign product = mul_a * mul_b;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign shifted = {rem, quo[DATA_W-1]};
  assign diff    = shifted - {1'b0, opb};
  assign fit     = ~diff[DATA_W];

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (op_q[1]) begin
      if (!div0) begin
        res_lo = cond_neg(quo, neg_q);
        res_hi = cond_neg(rem, neg_r);
      end
    end else begin
      res_hi = product[63:32];
      res_lo = product[31:0];
    end
  end

  // Operand / divider datapath (no reset; only meaningful once accepted).
  always_ff @(posedge clk) begin
    if (accept_long) begin
      op_q <= op[1:0];
      if (op[1]) begin
        quo   <= op[0] ? src1 : abs_val(src1);
        opb   <= op[0] ? src2 : abs_val(src2);
        opa   <= src1;
        rem   <= '0;
        neg_q <= ~op[0] & (src1[DATA_W-1] ^ src2[DATA_W-1]);
        neg_r <= ~op[0] & src1[DATA_W-1];
        div0  <= (src2 == '0);
      end else begin
        opa <= src1;
        opb <= src2;
      end
    end else if (state == DIV) begin
      rem <= fit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      quo <= {quo[DATA_W-2:0], fit};
    end
  end

  // Control FSM and architectural HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi <= src1;
              OP_MTLO: lo <= src1;
              OP_MULT, OP_MULTU: begin
                if (MUL_LAT == 1) begin
                  state <= FIN;
                end else begin
                  state <= MUL;
                  cnt   <= 6'(MUL_LAT - 2);
                end
              end
              OP_DIV, OP_DIVU: begin
                state <= DIV;
                cnt   <= 6'd31;
              end
              default: state <= IDLE;
            endcase
          end
        end
        MUL, DIV: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= FIN;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        FIN: begin
          state <= IDLE;
          if (!flush) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
